// File: rtl/axi_lite_pkt_validator.sv
// -----------------------------------------------------------------------------
// axi_lite_pkt_validator
//
// AXI-Lite write-only slave that stages packet words, checks the header byte
// when a packet is committed, and queues accepted packets in a FIFO that is
// drained through a valid/ready stream port.
//
// Register map (write-only, 8-bit address):
//   0x00 STAGE  : load the write data into the staging register
//   0x04 COMMIT : push the staged word if its header byte equals MAGIC and
//                 the FIFO is not full; otherwise respond SLVERR
//   0x08 FLUSH  : empty the FIFO and discard any staged word
//   other       : SLVERR, nothing changes
//
// Parameters:
//   DATA_W : packet/data width (multiple of 8, >= 16)
//   DEPTH  : FIFO entries (power of 2, >= 2)
//   MAGIC  : required value of data[DATA_W-1 -: 8]
//
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   aw_addr/aw_valid/aw_ready : write address channel
//   w_data/w_valid/w_ready  : write data channel
//   b_resp/b_valid/b_ready  : write response channel (00 OKAY, 10 SLVERR)
//   m_data/m_valid/m_ready  : output packet stream (FIFO head)
//   fifo_count              : FIFO occupancy, 0..DEPTH
//   accept_cnt, drop_cnt    : saturating statistics counters
//
// Build option:
//   PKT_VALIDATOR_STATS_EN  : when defined, accept_cnt/drop_cnt are 16-bit
//                             saturating counters; otherwise both read 0.
// -----------------------------------------------------------------------------
module axi_lite_pkt_validator #(
  parameter int         DATA_W = 32,
  parameter int         DEPTH  = 16,
  parameter logic [7:0] MAGIC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               aw_addr,
  input  logic                     aw_valid,
  output logic                     aw_ready,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  output logic [1:0]               b_resp,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              accept_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int         PW          = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [7:0] ADDR_STAGE  = 8'h00;
  localparam logic [7:0] ADDR_COMMIT = 8'h04;
  localparam logic [7:0] ADDR_FLUSH  = 8'h08;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EXEC    = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                aw_held;
  logic                w_held;
  logic                staged;
  logic [7:0]          addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   staging;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;

  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic exec;
  logic is_stage;
  logic is_commit;
  logic is_flush;
  logic commit_staged;
  logic hdr_ok;
  logic fifo_full;
  logic push;
  logic pop;
  logic [1:0] resp_d;

  // Readies are forced low while reset is asserted, even though the held
  // flags are already clear.
  assign aw_ready = rst_n && (state_q == COLLECT) && !aw_held;
  assign w_ready  = rst_n && (state_q == COLLECT) && !w_held;
  assign b_valid  = (state_q == RESP);

  assign aw_fire = aw_valid && aw_ready;
  assign w_fire  = w_valid && w_ready;
  assign b_fire  = b_valid && b_ready;

  // A channel completing in this cycle counts as held, so EXEC follows the
  // last handshake directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if ((aw_held || aw_fire) && (w_held || w_fire)) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (b_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // ---- Command decode (valid only during EXEC) ----
  assign exec          = (state_q == EXEC);
  assign is_stage      = exec && (addr_q == ADDR_STAGE);
  assign is_commit     = exec && (addr_q == ADDR_COMMIT);
  assign is_flush      = exec && (addr_q == ADDR_FLUSH);
  assign commit_staged = is_commit && staged;
  assign hdr_ok        = (staging[DATA_W-1 -: 8] == MAGIC);
  // Occupancy at the start of EXEC decides fullness; a same-cycle pop does
  // not make room for the commit.
  assign fifo_full     = (count == FULL_CNT);
  assign push          = commit_staged && hdr_ok && !fifo_full;
  assign pop           = m_valid && m_ready;
  assign resp_d        = (is_stage || is_flush || push) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      staged  <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (aw_fire)     aw_held <= 1'b1;
      else if (b_fire) aw_held <= 1'b0;
      if (w_fire)      w_held  <= 1'b1;
      else if (b_fire) w_held  <= 1'b0;
      if (exec)        b_resp  <= resp_d;
      if (is_stage)                        staged <= 1'b1;
      else if (commit_staged || is_flush)  staged <= 1'b0;
    end
  end

  // ---- FIFO pointers and occupancy; flush overrides any same-cycle pop ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (is_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- Datapath registers (no reset) ----
  always_ff @(posedge clk) begin
    if (aw_fire)  addr_q  <= aw_addr;
    if (w_fire)   wdata_q <= w_data;
    if (is_stage) staging <= wdata_q;
    if (push)     mem[wr_ptr] <= staging;
  end

  assign m_valid    = (count != '0);
  assign m_data     = mem[rd_ptr];
  assign fifo_count = count;

`ifdef PKT_VALIDATOR_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        drop;
  logic [15:0] accept_q;
  logic [15:0] drop_q;

  // Only commits of a staged word count as drops; an empty commit does not.
  assign drop = commit_staged && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_q <= 16'd0;
      drop_q   <= 16'd0;
    end else begin
      if (push) accept_q <= sat_inc(accept_q);
      if (drop) drop_q   <= sat_inc(drop_q);
    end
  end

  assign accept_cnt = accept_q;
  assign drop_cnt   = drop_q;
`else
  assign accept_cnt = 16'd0;
  assign drop_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_axi_lite_pkt_validator.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_pkt_validator
//
// Self-checking bench for axi_lite_pkt_validator. A queue-based reference
// model tracks the packet FIFO, the staged word and the statistics; every
// clock the stream outputs are compared with the model, and every write
// transaction's response, timing and readies are checked. Directed scenarios
// are followed by randomized transactions and a mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_axi_lite_pkt_validator;

  localparam int         DATA_W = 32;
  localparam int         DEPTH  = 16;
  localparam logic [7:0] MAGIC  = 8'hA5;

  logic                   clk;
  logic                   rst_n;
  logic [7:0]             aw_addr;
  logic                   aw_valid;
  logic                   aw_ready;
  logic [DATA_W-1:0]      w_data;
  logic                   w_valid;
  logic                   w_ready;
  logic [1:0]             b_resp;
  logic                   b_valid;
  logic                   b_ready;
  logic [DATA_W-1:0]      m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            accept_cnt;
  logic [15:0]            drop_cnt;

  axi_lite_pkt_validator #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  bit                m_staged;
  logic [DATA_W-1:0] m_staging;
  int                m_acc;
  int                m_drop;
  logic [1:0]        exp_resp;
  logic [7:0]        cur_addr;
  logic [DATA_W-1:0] cur_data;
  bit                last_aw_hs;
  bit                last_w_hs;
  int                mr_mode;  // 0 manual, 1 random, 2 only during EXEC

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_acc();
`ifdef PKT_VALIDATOR_STATS_EN
    return m_acc;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_drop();
`ifdef PKT_VALIDATOR_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_staged = 1'b0;
    m_acc    = 0;
    m_drop   = 0;
  endtask

  task automatic apply_cmd(input bit full_pre);
    logic [DATA_W-1:0] hdr_word;
    case (cur_addr)
      8'h00: begin
        m_staging = cur_data;
        m_staged  = 1'b1;
        exp_resp  = 2'b00;
      end
      8'h04: begin
        if (!m_staged) begin
          exp_resp = 2'b10;
        end else begin
          m_staged = 1'b0;
          hdr_word = m_staging;
          if (hdr_word[DATA_W-1 -: 8] == MAGIC && !full_pre) begin
            q.push_back(m_staging);
            m_acc    = sat16(m_acc);
            exp_resp = 2'b00;
          end else begin
            m_drop   = sat16(m_drop);
            exp_resp = 2'b10;
          end
        end
      end
      8'h08: begin
        q.delete();
        m_staged = 1'b0;
        exp_resp = 2'b00;
      end
      default: exp_resp = 2'b10;
    endcase
  endtask

  // One clock: compare stream outputs with the model mid-cycle, then advance
  // the model by the pop (if any) and, in the EXEC cycle, by the command.
  task automatic tick(input bit exec);
    bit pop;
    bit full_pre;
    if (mr_mode == 1)      m_ready = ($urandom_range(0, 2) == 0);
    else if (mr_mode == 2) m_ready = exec;
    @(negedge clk);
    pop        = m_valid && m_ready;
    last_aw_hs = aw_valid && aw_ready;
    last_w_hs  = w_valid && w_ready;
    chk("m_valid", m_valid, q.size() != 0);
    chk("fifo_count", fifo_count, q.size());
    if (q.size() != 0) chk("m_data", m_data, q[0]);
    full_pre = (q.size() == DEPTH);
    @(posedge clk);
    #1;
    if (pop && q.size() != 0) void'(q.pop_front());
    if (exec) apply_cmd(full_pre);
  endtask

  task automatic write_txn(input logic [7:0] addr, input logic [DATA_W-1:0] data,
                           input int aw_dly, input int w_dly, input int b_hold,
                           input bit abort);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int cyc     = 0;
    int lat     = 0;
    cur_addr = addr;
    cur_data = data;
    while (!(aw_done && w_done)) begin
      if (cyc > 40) begin
        chk("hs_timeout", aw_done && w_done, 1'b1);
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        return;
      end
      if (aw_done) chk("aw_ready_held", aw_ready, 1'b0);
      if (w_done)  chk("w_ready_held", w_ready, 1'b0);
      aw_valid = !aw_done && (cyc >= aw_dly);
      w_valid  = !w_done && (cyc >= w_dly);
      aw_addr  = addr;
      w_data   = data;
      tick(1'b0);
      if (last_aw_hs) aw_done = 1'b1;
      if (last_w_hs)  w_done  = 1'b1;
      cyc++;
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    // EXEC cycle
    chk("b_valid_exec", b_valid, 1'b0);
    chk("aw_ready_exec", aw_ready, 1'b0);
    chk("w_ready_exec", w_ready, 1'b0);
    tick(1'b1);
    while (!b_valid && lat < 10) begin
      tick(1'b0);
      lat++;
    end
    chk("b_latency", lat, 0);
    if (!b_valid) return;
    chk("b_resp", b_resp, exp_resp);
    if (abort) return;
    b_ready = 1'b0;
    for (int i = 0; i < b_hold; i++) begin
      chk("aw_ready_resp", aw_ready, 1'b0);
      chk("w_ready_resp", w_ready, 1'b0);
      tick(1'b0);
      chk("b_valid_hold", b_valid, 1'b1);
      chk("b_resp_hold", b_resp, exp_resp);
    end
    b_ready = 1'b1;
    tick(1'b0);
    b_ready = 1'b0;
    chk("b_valid_done", b_valid, 1'b0);
    chk("aw_ready_back", aw_ready, 1'b1);
    chk("w_ready_back", w_ready, 1'b1);
    chk("accept_cnt", accept_cnt, exp_acc());
    chk("drop_cnt", drop_cnt, exp_drop());
  endtask

  task automatic put_pkt(input logic [DATA_W-1:0] data);
    write_txn(8'h00, data, 0, 0, 0, 1'b0);
    write_txn(8'h04, 32'h0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_aw_ready"}, aw_ready, 1'b0);
    chk({tag, "_w_ready"}, w_ready, 1'b0);
    chk({tag, "_b_valid"}, b_valid, 1'b0);
    chk({tag, "_b_resp"}, b_resp, 2'b00);
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_accept_cnt"}, accept_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]        a;
    logic [DATA_W-1:0] d;
    rst_n    = 1'b0;
    aw_addr  = 8'h00;
    aw_valid = 1'b0;
    w_data   = '0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    m_ready  = 1'b0;
    mr_mode  = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", aw_ready && w_ready, 1'b1);

    // Valid packet
    put_pkt(32'hA500_1234);
    chk("pkt1_count", fifo_count, 1);
    chk("pkt1_data", m_data, 32'hA500_1234);
    m_ready = 1'b1;
    tick(1'b0);
    m_ready = 1'b0;

    // Bad header, then commit with nothing staged
    put_pkt(32'h5A00_0001);
    chk("bad_hdr_resp", b_resp, 2'b10);
    write_txn(8'h04, 32'h0, 0, 0, 0, 1'b0);
    chk("empty_commit_resp", b_resp, 2'b10);

    // W three cycles before AW, B held off for five cycles
    write_txn(8'h00, 32'hA5AB_CDEF, 3, 0, 5, 1'b0);
    write_txn(8'h04, 32'h0, 0, 2, 1, 1'b0);

    // Fill to DEPTH, overflow, then drain on consecutive cycles
    m_ready = 1'b1;
    repeat (2) tick(1'b0);
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) put_pkt({MAGIC, 24'(i * 24'h010101 + 24'h17)});
    chk("fill_count", fifo_count, DEPTH);
    put_pkt({MAGIC, 24'hFFFFFF});
    chk("overflow_resp", b_resp, 2'b10);
    m_ready = 1'b1;
    repeat (DEPTH) tick(1'b0);
    chk("drained_count", fifo_count, 0);
    m_ready = 1'b0;

    // Flush with five entries and a same-cycle pop
    for (int i = 0; i < 5; i++) put_pkt({MAGIC, 24'($urandom)});
    mr_mode = 2;
    write_txn(8'h08, 32'h0, 0, 0, 0, 1'b0);
    mr_mode = 0;
    m_ready = 1'b0;
    chk("flush_count", fifo_count, 0);
    chk("flush_m_valid", m_valid, 1'b0);

    // Stray address leaves staged word intact
    write_txn(8'h00, 32'hA512_3456, 0, 0, 0, 1'b0);
    write_txn(8'h0C, 32'hDEAD_BEEF, 1, 0, 0, 1'b0);
    chk("stray_resp", b_resp, 2'b10);
    write_txn(8'h04, 32'h0, 0, 0, 0, 1'b0);
    chk("after_stray_data", m_data, 32'hA512_3456);

    // Randomized traffic
    mr_mode = 1;
    repeat (200) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 8'h00;
        4, 5, 6, 7: a = 8'h04;
        8:          a = 8'h08;
        default:    a = 8'($urandom);
      endcase
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[DATA_W-1 -: 8] = MAGIC;
      write_txn(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end
    mr_mode = 0;
    m_ready = 1'b0;

    // Reset during RESP with three queued packets
    write_txn(8'h08, 32'h0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) put_pkt({MAGIC, 24'(i + 1)});
    write_txn(8'h00, 32'hA577_7777, 0, 0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #1;
    chk("midreset_held_aw_ready", aw_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", aw_ready && w_ready, 1'b1);
    chk("post_reset_b_valid", b_valid, 1'b0);
    write_txn(8'h04, 32'h0, 0, 0, 0, 1'b0);
    chk("post_reset_stage_lost", b_resp, 2'b10);
    put_pkt(32'hA5CA_FE00);
    chk("post_reset_count", fifo_count, 1);
    chk("post_reset_data", m_data, 32'hA5CA_FE00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
